// File: rtl/dbus_timer_if.sv
// Data-memory bus bundle between the core and the dbus_timer responder.
//   master : core side; drives address, write data and strobes, receives read data,
//            hit and irq.
//   slave  : timer side; the mirror image.
// Signals:
//   daddr    [31:0] byte address
//   ddata_w  [31:0] write data
//   MemWrite        write strobe, one word per cycle while high
//   MemRead         read strobe
//   ddata_r  [31:0] read data, zero when the access is outside the window
//   hit             access decodes to the timer window
//   irq             level interrupt, active-high
interface dbus_timer_if;
  logic [31:0] daddr;
  logic [31:0] ddata_w;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ddata_r;
  logic        hit;
  logic        irq;

  modport master (
    output daddr,
    output ddata_w,
    output MemWrite,
    output MemRead,
    input  ddata_r,
    input  hit,
    input  irq
  );

  modport slave (
    input  daddr,
    input  ddata_w,
    input  MemWrite,
    input  MemRead,
    output ddata_r,
    output hit,
    output irq
  );
endinterface

// File: rtl/dbus_timer.sv
// Memory-mapped timer on the core data bus, sitting in parallel with the data RAM.
// Four word registers in a 16-byte window at BASE_ADDR:
//   0x0 CTRL    [0] EN, [1] AUTO, [2] IE, [15:8] PRESCALE
//   0x4 COUNT   32-bit up-counter
//   0x8 COMPARE match value
//   0xC STATUS  [0] MATCH (write 1 to clear), [1] RUN (mirrors EN)
// Ports:
//   CLK    system clock, rising edge
//   RESET  synchronous, active-high
//   bus    dbus_timer_if.slave (daddr, ddata_w, MemWrite, MemRead, ddata_r, hit, irq)
// ddata_r is zero unless this window is read, so it can be ORed with the RAM output.
// Build option: define DBUS_TIMER_PRESCALER_EN to include the PRESCALE field and the
// 8-bit prescale counter; without it every enabled cycle is a tick and CTRL[15:8]
// reads 0.
module dbus_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000
) (
  input logic         CLK,
  input logic         RESET,
  dbus_timer_if.slave bus
);

  typedef enum logic [1:0] {
    RegCtrl    = 2'd0,
    RegCount   = 2'd1,
    RegCompare = 2'd2,
    RegStatus  = 2'd3
  } reg_sel_e;

  logic        en_q, en_d;
  logic        auto_q, auto_d;
  logic        ie_q, ie_d;
  logic        match_q, match_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
`ifdef DBUS_TIMER_PRESCALER_EN
  logic [7:0]  presc_q, presc_d;
  logic [7:0]  pcnt_q, pcnt_d;
`endif

  logic        hit;
  logic        wr;
  reg_sel_e    sel;
  logic        wr_ctrl, wr_count, wr_compare, wr_status;
  logic        tick;
  logic        match_hit;
  logic [31:0] rdata;

  // Byte lane bits are irrelevant to a word-only register file.
  logic        unused_addr;
  assign unused_addr = ^bus.daddr[1:0];

  assign hit = (bus.daddr[31:4] == BASE_ADDR[31:4]) && (bus.MemRead || bus.MemWrite);
  assign wr  = hit && bus.MemWrite;
  assign sel = reg_sel_e'(bus.daddr[3:2]);

  assign wr_ctrl    = wr && (sel == RegCtrl);
  assign wr_count   = wr && (sel == RegCount);
  assign wr_compare = wr && (sel == RegCompare);
  assign wr_status  = wr && (sel == RegStatus);

`ifdef DBUS_TIMER_PRESCALER_EN
  assign tick = en_q && (pcnt_q == presc_q);
`else
  assign tick = en_q;
`endif

  // Compare uses the pre-edge COUNT even when the bus overwrites COUNT this cycle.
  assign match_hit = tick && (count_q == compare_q);

  always_comb begin
    en_d      = en_q;
    auto_d    = auto_q;
    ie_d      = ie_q;
    match_d   = match_q;
    count_d   = count_q;
    compare_d = compare_q;
`ifdef DBUS_TIMER_PRESCALER_EN
    presc_d   = presc_q;
    // Counter idles at 0 while disabled and restarts on any CTRL write.
    if (!en_q || tick || wr_ctrl) begin
      pcnt_d = 8'd0;
    end else begin
      pcnt_d = pcnt_q + 8'd1;
    end
`endif

    // W1C first so a same-cycle match set takes precedence below.
    if (wr_status && bus.ddata_w[0]) begin
      match_d = 1'b0;
    end

    if (tick) begin
      if (match_hit) begin
        match_d = 1'b1;
        if (auto_q) begin
          count_d = 32'd0;
        end else begin
          en_d = 1'b0;
        end
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    // Bus writes last: they override the tick's COUNT update and one-shot EN clear.
    if (wr_ctrl) begin
      en_d   = bus.ddata_w[0];
      auto_d = bus.ddata_w[1];
      ie_d   = bus.ddata_w[2];
`ifdef DBUS_TIMER_PRESCALER_EN
      presc_d = bus.ddata_w[15:8];
`endif
    end
    if (wr_count) begin
      count_d = bus.ddata_w;
    end
    if (wr_compare) begin
      compare_d = bus.ddata_w;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      en_q      <= 1'b0;
      auto_q    <= 1'b0;
      ie_q      <= 1'b0;
      match_q   <= 1'b0;
      count_q   <= 32'd0;
      compare_q <= 32'd0;
`ifdef DBUS_TIMER_PRESCALER_EN
      presc_q   <= 8'd0;
      pcnt_q    <= 8'd0;
`endif
    end else begin
      en_q      <= en_d;
      auto_q    <= auto_d;
      ie_q      <= ie_d;
      match_q   <= match_d;
      count_q   <= count_d;
      compare_q <= compare_d;
`ifdef DBUS_TIMER_PRESCALER_EN
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
`endif
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (hit && bus.MemRead) begin
      unique case (sel)
`ifdef DBUS_TIMER_PRESCALER_EN
        RegCtrl:    rdata = {16'd0, presc_q, 5'd0, ie_q, auto_q, en_q};
`else
        RegCtrl:    rdata = {29'd0, ie_q, auto_q, en_q};
`endif
        RegCount:   rdata = count_q;
        RegCompare: rdata = compare_q;
        RegStatus:  rdata = {30'd0, en_q, match_q};
        default:    rdata = 32'd0;
      endcase
    end
  end

  assign bus.ddata_r = rdata;
  assign bus.hit     = hit;
  assign bus.irq     = match_q && ie_q;

endmodule

// File: tb/tb_dbus_timer.sv
module tb_dbus_timer;

`ifdef DBUS_TIMER_PRESCALER_EN
  localparam int unsigned Per     = 4;
  localparam logic [31:0] Ctrl303 = 32'h0000_0303;
  localparam logic [31:0] Ctrl301 = 32'h0000_0301;
`else
  localparam int unsigned Per     = 1;
  localparam logic [31:0] Ctrl303 = 32'h0000_0003;
  localparam logic [31:0] Ctrl301 = 32'h0000_0001;
`endif

  localparam logic [31:0] ACtrl   = 32'h0000_2000;
  localparam logic [31:0] ACount  = 32'h0000_2004;
  localparam logic [31:0] ACmp    = 32'h0000_2008;
  localparam logic [31:0] AStatus = 32'h0000_200C;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dbus_timer_if bus ();

  dbus_timer #(
    .BASE_ADDR(32'h0000_2000)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write lands on the next rising edge; returns just after that edge.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.daddr    = addr;
    bus.ddata_w  = data;
    bus.MemWrite = 1'b1;
    bus.MemRead  = 1'b0;
    @(posedge clk);
    #1;
    bus.MemWrite = 1'b0;
  endtask

  // Combinational read in the low phase; sees state after the preceding edge.
  task automatic rd(input logic [31:0] addr, output logic [31:0] data, output logic h,
                    output logic iq);
    @(negedge clk);
    bus.daddr    = addr;
    bus.MemRead  = 1'b1;
    bus.MemWrite = 1'b0;
    #1;
    data = bus.ddata_r;
    h    = bus.hit;
    iq   = bus.irq;
    bus.MemRead = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        h, iq;
    logic [31:0] addrs [4];
    addrs = '{ACtrl, ACount, ACmp, AStatus};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rd(addrs[i], d, h, iq);
      checks++;
      if (d !== 32'd0 || h !== 1'b1 || iq !== 1'b0) begin
        errors++;
        $display("FAIL reset_reg%0d: got data=%h hit=%b irq=%b, want data=0 hit=1 irq=0",
                 i, d, h, iq);
      end
    end
    rd(32'h0000_1000, d, h, iq);
    checks++;
    if (d !== 32'd0 || h !== 1'b0) begin
      errors++;
      $display("FAIL reset_outside: got data=%h hit=%b, want data=0 hit=0", d, h);
    end
  endtask

  task automatic test_one_shot();
    logic [31:0] d;
    logic        h, iq;
    do_reset();
    wr(ACmp, 32'd5);
    wr(ACtrl, 32'h0000_0005);
    for (int t = 0; t < 8; t++) begin
      rd(ACount, d, h, iq);
      checks++;
      if (d !== ((t < 5) ? 32'(t) : 32'd5) || iq !== (t >= 6)) begin
        errors++;
        $display("FAIL oneshot_t%0d: got count=%0d irq=%b, want count=%0d irq=%b",
                 t, d, iq, (t < 5) ? t : 5, (t >= 6));
      end
    end
    rd(AStatus, d, h, iq);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL oneshot_status: got %h want 00000001", d);
    end
    wr(AStatus, 32'h1);
    rd(AStatus, d, h, iq);
    checks++;
    if (d !== 32'h0 || iq !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_w1c: got status=%h irq=%b, want status=0 irq=0", d, iq);
    end
  endtask

  task automatic test_auto_reload();
    logic [31:0] d;
    logic        h, iq;
    do_reset();
    wr(ACmp, 32'd2);
    wr(ACtrl, 32'h0000_0303);
    for (int t = 0; t < 15; t++) begin
      rd(ACount, d, h, iq);
      checks++;
      if (d !== 32'((t / Per) % 3)) begin
        errors++;
        $display("FAIL auto_t%0d: got count=%0d want %0d", t, d, (t / Per) % 3);
      end
    end
    rd(AStatus, d, h, iq);
    checks++;
    if (d !== 32'h3 || iq !== 1'b0) begin
      errors++;
      $display("FAIL auto_status: got status=%h irq=%b, want status=3 irq=0", d, iq);
    end
    rd(ACtrl, d, h, iq);
    checks++;
    if (d !== Ctrl303) begin
      errors++;
      $display("FAIL auto_ctrl: got %h want %h", d, Ctrl303);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    logic [31:0] exp;
    logic        h, iq;
    do_reset();
    wr(ACount, 32'hFFFF_FFFE);
    wr(ACmp, 32'd3);
    wr(ACtrl, 32'h0000_0001);
    for (int t = 0; t < 8; t++) begin
      if (t % 2 == 0) begin
        rd(ACount, d, h, iq);
        exp = (t <= 5) ? 32'hFFFF_FFFE + 32'(t) : 32'd3;
      end else begin
        rd(AStatus, d, h, iq);
        exp = (t >= 6) ? 32'h1 : 32'h2;
      end
      checks++;
      if (d !== exp) begin
        errors++;
        $display("FAIL wrap_t%0d: got %h want %h", t, d, exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    logic        h, iq;
    do_reset();
    wr(ACmp, 32'h0000_FFFF);
    wr(ACtrl, 32'h0000_0301);
    repeat (Per - 1) @(posedge clk);
    wr(ACount, 32'd100);
    rd(ACount, d, h, iq);
    checks++;
    if (d !== 32'd100) begin
      errors++;
      $display("FAIL simul_count_write: got %0d want 100", d);
    end
    do_reset();
    wr(ACtrl, 32'h0000_0301);
    repeat (Per - 1) @(posedge clk);
    wr(AStatus, 32'h1);
    rd(AStatus, d, h, iq);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL simul_match_vs_w1c: got %h want 00000001", d);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] d;
    logic        h, iq;
    do_reset();
    wr(ACmp, 32'h0000_FFFF);
    wr(ACount, 32'd7);
    wr(ACtrl, 32'h0000_0005);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd(ACount, d, h, iq);
    checks++;
    if (d !== 32'd0 || iq !== 1'b0) begin
      errors++;
      $display("FAIL midreset_count: got count=%0d irq=%b, want 0/0", d, iq);
    end
    rd(ACtrl, d, h, iq);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL midreset_ctrl: got %h want 0", d);
    end
    wr(ACmp, 32'h0000_FFFF);
    wr(ACtrl, 32'h0000_0301);
    for (int t = 0; t < 4; t++) begin
      rd(ACount, d, h, iq);
      checks++;
      if (d !== 32'(t / Per)) begin
        errors++;
        $display("FAIL midreset_run_t%0d: got %0d want %0d", t, d, t / Per);
      end
    end
    rd(ACtrl, d, h, iq);
    checks++;
    if (d !== Ctrl301) begin
      errors++;
      $display("FAIL midreset_ctrl_rb: got %h want %h", d, Ctrl301);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.daddr    = 32'd0;
    bus.ddata_w  = 32'd0;
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b0;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_wrap();
    test_simultaneous();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Backstop so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion, want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
